// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file : 32 x WIDTH general-purpose register file for the single-cycle
//            MIPS datapath.
//
// Ports
//   Clk     in   1      rising-edge clock
//   Clrn    in   1      asynchronous active-low reset (registers and counter)
//   N1      in   5      read address, port 1 (rs)
//   N2      in   5      read address, port 2 (rt)
//   ND      in   5      write address (rd or rt)
//   DI      in   WIDTH  write data
//   WE      in   1      write enable, active high
//   DBG_N   in   5      debug read address
//   Q1      out  WIDTH  read data, port 1 (combinational)
//   Q2      out  WIDTH  read data, port 2 (combinational)
//   DBG_Q   out  WIDTH  debug read data (combinational)
//   WR_CNT  out  CNT_W  committed writes since reset (registered, wraps)
//
// Register 0 has no storage and always reads zero.  With BYPASS=1 a read of
// the register being written this cycle returns DI instead of the stored value.
// -----------------------------------------------------------------------------
module reg_file #(
   parameter int WIDTH  = 32,
   parameter bit BYPASS = 1'b0,
   parameter int CNT_W  = 16
) (
   input  logic             Clk,
   input  logic             Clrn,
   input  logic [4:0]       N1,
   input  logic [4:0]       N2,
   input  logic [4:0]       ND,
   input  logic [WIDTH-1:0] DI,
   input  logic             WE,
   input  logic [4:0]       DBG_N,
   output logic [WIDTH-1:0] Q1,
   output logic [WIDTH-1:0] Q2,
   output logic [WIDTH-1:0] DBG_Q,
   output logic [CNT_W-1:0] WR_CNT
);

   logic [WIDTH-1:0] regs_r [1:31];
   logic [CNT_W-1:0] wr_cnt_r;
   logic             wr_en_s;
   logic             byp_en_s;

   // A write to $0 is discarded, so it must neither store nor count.
   assign wr_en_s  = WE && (ND != 5'd0);
   // Forwarding is suppressed while in reset so all ports read zero.
   assign byp_en_s = BYPASS && Clrn && wr_en_s;

   // Read mux for one port: $0 reads zero, optional forwarding of DI.
   function automatic logic [WIDTH-1:0] read_port(input logic [4:0] addr);
      logic [WIDTH-1:0] val;
      val = {WIDTH{1'b0}};
      if (byp_en_s && (addr == ND)) begin
         val = DI;
      end else begin
         for (int i = 1; i < 32; i++) begin
            if (addr == 5'(i)) begin
               val = regs_r[i];
            end else begin
               val = val;
            end
         end
      end
      return val;
   endfunction

   // Register storage and committed-write counter.
   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         for (int i = 1; i < 32; i++) begin
            regs_r[i] <= {WIDTH{1'b0}};
         end
         wr_cnt_r <= {CNT_W{1'b0}};
      end else begin
         for (int i = 1; i < 32; i++) begin
            if (wr_en_s && (ND == 5'(i))) begin
               regs_r[i] <= DI;
            end
         end
         if (wr_en_s) begin
            wr_cnt_r <= wr_cnt_r + CNT_W'(1);
         end
      end
   end

   // Combinational read ports.
   always_comb begin
      Q1    = {WIDTH{1'b0}};
      Q2    = {WIDTH{1'b0}};
      DBG_Q = {WIDTH{1'b0}};
      Q1    = read_port(N1);
      Q2    = read_port(N2);
      DBG_Q = read_port(DBG_N);
   end

   assign WR_CNT = wr_cnt_r;

endmodule

// File: tb/tb_reg_file.sv
// -----------------------------------------------------------------------------
// tb_reg_file : self-checking bench for reg_file.  Two instances share the
// stimulus: u_b0 (BYPASS=0, CNT_W=16) and u_b1 (BYPASS=1, CNT_W=4).  Expected
// values come from a plain array model plus a write tally.
// -----------------------------------------------------------------------------
module tb_reg_file;

   logic        clk;
   logic        clrn;
   logic [4:0]  n1, n2, nd, dbg_n;
   logic [31:0] di;
   logic        we;

   logic [31:0] q1_a, q2_a, dq_a;
   logic [15:0] cnt_a;
   logic [31:0] q1_b, q2_b, dq_b;
   logic [3:0]  cnt_b;

   logic [31:0] m [32];
   int unsigned nwr;
   int          checks;
   int          errors;

   reg_file #(.WIDTH(32), .BYPASS(1'b0), .CNT_W(16)) u_b0 (
      .Clk(clk), .Clrn(clrn), .N1(n1), .N2(n2), .ND(nd), .DI(di), .WE(we),
      .DBG_N(dbg_n), .Q1(q1_a), .Q2(q2_a), .DBG_Q(dq_a), .WR_CNT(cnt_a)
   );

   reg_file #(.WIDTH(32), .BYPASS(1'b1), .CNT_W(4)) u_b1 (
      .Clk(clk), .Clrn(clrn), .N1(n1), .N2(n2), .ND(nd), .DI(di), .WE(we),
      .DBG_N(dbg_n), .Q1(q1_b), .Q2(q2_b), .DBG_Q(dq_b), .WR_CNT(cnt_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected read for address a; byp selects the forwarding variant.
   function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
      if (a == 5'd0) return 32'd0;
      if (byp && clrn && we && (nd != 5'd0) && (a == nd)) return di;
      return m[a];
   endfunction

   task automatic check_all(input string ph);
      chk({ph, " q1_b0"},  q1_a, exp_rd(n1, 1'b0));
      chk({ph, " q2_b0"},  q2_a, exp_rd(n2, 1'b0));
      chk({ph, " dbg_b0"}, dq_a, exp_rd(dbg_n, 1'b0));
      chk({ph, " q1_b1"},  q1_b, exp_rd(n1, 1'b1));
      chk({ph, " q2_b1"},  q2_b, exp_rd(n2, 1'b1));
      chk({ph, " dbg_b1"}, dq_b, exp_rd(dbg_n, 1'b1));
      chk({ph, " cnt16"},  {16'd0, cnt_a}, {16'd0, nwr[15:0]});
      chk({ph, " cnt4"},   {28'd0, cnt_b}, {28'd0, nwr[3:0]});
   endtask

   task automatic model_clear();
      for (int i = 0; i < 32; i++) m[i] = 32'd0;
      nwr = 0;
   endtask

   // One clock cycle; called just after a falling edge.
   task automatic cycle(input logic w, input logic [4:0] a_nd, input logic [31:0] a_di,
                        input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
      we = w; nd = a_nd; di = a_di; n1 = a1; n2 = a2; dbg_n = ad;
      #1;
      check_all("pre");
      @(posedge clk);
      if (clrn && we && (nd != 5'd0)) begin
         m[nd] = di;
         nwr++;
      end
      #1;
      check_all("post");
      @(negedge clk);
   endtask

   // Mid-cycle reset pulse; reads must drop to zero before any clock edge.
   task automatic reset_pulse();
      #2;
      clrn = 1'b0;
      model_clear();
      #1;
      check_all("rst");
      @(negedge clk);
      clrn = 1'b1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      model_clear();
      clrn = 1'b0;
      we = 1'b0; nd = 5'd0; di = 32'd0; n1 = 5'd3; n2 = 5'd31; dbg_n = 5'd0;
      #3;
      check_all("reset");
      @(negedge clk);
      clrn = 1'b1;

      // Write reg 5, then a reset pulse clears it before the next edge.
      cycle(1'b1, 5'd5, 32'h12345678, 5'd5, 5'd5, 5'd5);
      cycle(1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 5'd5);
      n1 = 5'd5;
      reset_pulse();
      chk("rst_q1_reg5", q1_a, 32'd0);
      chk("rst_cnt", {16'd0, cnt_a}, 32'd0);

      // A write presented while in reset is lost.
      clrn = 1'b0;
      cycle(1'b1, 5'd6, 32'hCAFEF00D, 5'd6, 5'd6, 5'd6);
      clrn = 1'b1;
      cycle(1'b0, 5'd0, 32'd0, 5'd6, 5'd6, 5'd6);
      chk("rst_drop_w6", q1_a, 32'd0);

      // Basic write/read.
      cycle(1'b1, 5'd8, 32'hDEADBEEF, 5'd1, 5'd2, 5'd3);
      cycle(1'b0, 5'd0, 32'd0, 5'd8, 5'd8, 5'd8);
      chk("basic_q1", q1_a, 32'hDEADBEEF);
      chk("basic_q2", q2_a, 32'hDEADBEEF);
      chk("basic_cnt", {16'd0, cnt_a}, 32'd1);

      // $0 protection.
      cycle(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
      chk("zero_q1", q1_a, 32'd0);
      chk("zero_cnt", {16'd0, cnt_a}, 32'd1);

      // Same-cycle hazard on reg 9.
      cycle(1'b1, 5'd9, 32'h1, 5'd0, 5'd0, 5'd0);
      we = 1'b1; nd = 5'd9; di = 32'h2; n1 = 5'd9; n2 = 5'd9; dbg_n = 5'd9;
      #1;
      chk("haz_pre_b0", q1_a, 32'h1);
      chk("haz_pre_b1", q1_b, 32'h2);
      chk("haz_dbg_b1", dq_b, 32'h2);
      cycle(1'b1, 5'd9, 32'h2, 5'd9, 5'd9, 5'd9);
      chk("haz_post_b0", q1_a, 32'h2);

      // X on ND/DI with WE low must not corrupt state.
      cycle(1'b0, 5'bxxxxx, 32'hxxxxxxxx, 5'd8, 5'd9, 5'd5);

      // Full sweep from a clean reset.
      reset_pulse();
      for (int i = 1; i < 32; i++) begin
         cycle(1'b1, 5'(i), i * 32'h01010101, 5'(i), 5'(32 - i), 5'(i - 1));
         if (i == 17) chk("wrap_cnt4_17", {28'd0, cnt_b}, 32'd1);
      end
      for (int i = 0; i < 32; i++) begin
         cycle(1'b0, 5'd0, 32'd0, 5'(i), 5'(i), 5'(i));
         chk("sweep_q1", q1_a, (i == 0) ? 32'd0 : i * 32'h01010101);
      end
      chk("sweep_cnt", {16'd0, cnt_a}, 32'd31);
      chk("sweep_cnt4", {28'd0, cnt_b}, 32'd15);

      // Randomized traffic against the model.
      for (int k = 0; k < 300; k++) begin
         cycle(1'($urandom_range(0, 1)), 5'($urandom), $urandom,
               5'($urandom), 5'($urandom), 5'($urandom));
         if (k == 150) reset_pulse();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- 32 x 32-bit general-purpose register file for the single-cycle MIPS datapath.
- It is the consumer of the write-register selection: ND (rd/rt, chosen by REGRT) names the destination, DI carries the writeback data, and WE commits the write on the clock edge.
- Two asynchronous read ports feed the ALU operands (rs, rt).
- A third read-only debug port and a committed-write counter support bench and board inspection.

Parameters:
- WIDTH, 32, data width of each register.
- BYPASS, 0, when 1 a read of the register being written this cycle returns DI instead of the stored value.
- CNT_W, 16, width of the committed-write counter.

Ports:
- Clk  input  1  rising-edge clock.
- Clrn  input  1  asynchronous active-low reset; clears all registers and the counter.
- N1  input  5  read address port 1 (rs, instr[25:21]).
- N2  input  5  read address port 2 (rt, instr[20:16]).
- ND  input  5  write address (rd or rt, from the destination mux).
- DI  input  WIDTH  write data.
- WE  input  1  write enable, active high.
- DBG_N  input  5  debug read address.
- Q1  output  WIDTH  read data port 1.
- Q2  output  WIDTH  read data port 2.
- DBG_Q  output  WIDTH  debug read data.
- WR_CNT  output  CNT_W  number of committed writes since reset.

Behaviour:
- Storage: registers 1..31 are flops. Register 0 is not stored and always reads 0.
- Reset: Clrn low clears registers 1..31 and WR_CNT to 0 immediately, with no clock needed.
  - Q1, Q2 and DBG_Q therefore read 0 for every address while Clrn is low.
  - Reset asserted mid-operation overrides any write in the same cycle; that write is lost.
  - The first write is accepted on the first rising Clk edge with Clrn high.
- Write: on rising Clk, if Clrn=1, WE=1 and ND!=0, reg[ND] <= DI and WR_CNT increments by 1.
  - ND=0 with WE=1 is a silent discard: no storage change, no count.
  - WE=0: no change.
- Counter: WR_CNT wraps from 2^CNT_W-1 to 0 without saturation or flag.
- Read (combinational, zero latency): Q1 = reg[N1], Q2 = reg[N2], DBG_Q = reg[DBG_N]. Any address 0 returns 0.
- Same-cycle read/write of the same address:
  - BYPASS=0: read returns the old value until the edge and the new value after it.
  - BYPASS=1: when WE=1, ND!=0 and Nx==ND, Qx = DI combinationally. This applies independently to Q1, Q2 and DBG_Q.
- N1==N2 is legal; both ports return the same data.
- Reads have no side effects; there is no read enable.
- X on ND or DI while WE=0 must not corrupt state.

Test Plan:
- Reset/zero: pulse Clrn low mid-cycle after writing reg 5 = 0x12345678 -> Q1 with N1=5 drops to 0 before the next edge; WR_CNT=0.
- Basic write/read: WE=1, ND=8, DI=0xDEADBEEF, one edge; then N1=8, N2=8 -> Q1=Q2=0xDEADBEEF; WR_CNT=1.
- $0 protection: WE=1, ND=0, DI=0xFFFFFFFF, edge -> Q1 with N1=0 is 0; WR_CNT unchanged.
- Same-cycle hazard: reg 9 = 0x1, then WE=1, ND=9, DI=0x2 with N1=9 before the edge.
  - BYPASS=0: Q1=0x1 before the edge, 0x2 after.
  - BYPASS=1: Q1=0x2 before the edge.
- Full sweep: write reg i = i*0x01010101 for i=1..31, then read every address on all three ports -> values match, reg 0 = 0, WR_CNT=31.
- Wrap: with CNT_W=4, perform 17 valid writes -> WR_CNT=1.
